serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 166 ++++++++++++++++
 tb/tb_serial_adder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial / chunk-serial adder-subtractor.
// Each RUN cycle adds CHUNK bits of the captured operands plus the running
// carry. After WIDTH/CHUNK cycles the full result, carry-out and signed
// overflow are published together and done pulses for one cycle.
//
// The captured operands are kept in shift registers that move right by CHUNK
// every RUN cycle, so the live chunk is always in the low CHUNK bits. The
// partial sum is shifted in from the top of a private accumulator. This means
// that after the last chunk the accumulator holds the result in natural bit
// order. The accumulator is never visible on s. Because of that, an aborted
// operation cannot leak a partial result.

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    // Reject parameter sets that would leave a ragged final chunk.
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("serial_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] s_q,     s_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [CHUNK:0]   chunk_sum;
    logic             msb_carry_in;
    logic [WIDTH-1:0] acc_shifted;

    // Chunk datapath: add the low chunk of each operand shift register plus
    // the running carry. The carry into the top bit of the chunk is found
    // from sum ^ a ^ b at that bit. It is only used on the last chunk, where
    // that bit is the MSB of the whole word.
    always_comb begin
        chunk_sum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};
        msb_carry_in = chunk_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
        acc_shifted  = (acc_q >> CHUNK)
                     | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    // Next-state logic for the control FSM and every datapath register.
    // The outputs are registered and only change on the RUN-to-DONE edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                if (start) begin
                    // Subtraction is a + ~b + ~cin, which equals a - b - cin.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end

            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_sum[CHUNK];
                acc_d   = acc_shifted;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = acc_shifted;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = chunk_sum[CHUNK] ^ msb_carry_in;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything at once so that
    // an aborted operation leaves no trace on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder.
// Two instances run from one clock: the default 8-bit/1-bit configuration and
// a 16-bit/4-bit configuration. Expected results are queued when a start is
// driven and are popped when done is seen. Each queued entry carries the
// cycle at which done must appear, so latency is checked as well as the data.

module tb_serial_adder;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk;
    int          cycle_cnt;
    int          n_checks;
    int          n_fail;

    logic        rst8, start8, sub8, cin8;
    logic [7:0]  a8, b8, s8;
    logic        cout8, ovf8, busy8, done8;

    logic        rst16, start16, sub16, cin16;
    logic [15:0] a16, b16, s16;
    logic        cout16, ovf16, busy16, done16;

    exp_t        q8[$];
    exp_t        q16[$];
    logic [7:0]  last_s8;
    logic [15:0] last_s16;

    serial_adder dut8 (
        .clk   (clk),
        .rst   (rst8),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .s     (s8),
        .cout  (cout8),
        .ovf   (ovf8),
        .busy  (busy8),
        .done  (done8)
    );

    serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk   (clk),
        .rst   (rst16),
        .start (start16),
        .sub   (sub16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .s     (s16),
        .cout  (cout16),
        .ovf   (ovf16),
        .busy  (busy16),
        .done  (done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cycle_cnt);
        end
    endtask

    // Reference arithmetic: a full-width sum, with overflow taken from the
    // operand and result sign bits.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin);
        exp_t        e;
        logic [15:0] mask;
        logic [15:0] be;
        logic [15:0] am;
        logic [16:0] full;
        int          msb;
        mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
        msb    = w - 1;
        am     = a & mask;
        be     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, be} + {16'd0, (sub ? ~cin : cin)};
        e.s    = full[15:0] & mask;
        e.cout = full[w];
        e.ovf  = (am[msb] == be[msb]) && (e.s[msb] != am[msb]);
        e.cyc  = 0;
        return e;
    endfunction

    // Drive one start pulse on the 8-bit instance from a negedge and queue
    // the expected result. Operands are scrambled after capture.
    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                  input logic cin, input logic [7:0] es, input logic ec,
                                  input logic eo);
        exp_t e;
        a8 = a; b8 = b; sub8 = sub; cin8 = cin; start8 = 1'b1;
        e.s = {8'd0, es}; e.cout = ec; e.ovf = eo; e.cyc = cycle_cnt + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    endtask

    // Drive one start pulse on the 16-bit instance from a negedge and queue
    // the expected result.
    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                   input logic cin, input logic [15:0] es, input logic ec,
                                   input logic eo);
        exp_t e;
        a16 = a; b16 = b; sub16 = sub; cin16 = cin; start16 = 1'b1;
        e.s = es; e.cout = ec; e.ovf = eo; e.cyc = cycle_cnt + 1 + 4;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); cin16 = 1'($urandom);
    endtask

    // Wait at negedges until done is seen, with a bounded cycle budget.
    task automatic waitDone8();
        int n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) checkOutput("timeout8", 32'd0, 32'd1);
    endtask

    // Wait at negedges until done is seen, with a bounded cycle budget.
    task automatic waitDone16();
        int n = 0;
        while (done16 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) checkOutput("timeout16", 32'd0, 32'd1);
    endtask

    // Monitor: pop and compare on each done, and check that s holds its
    // previous value while an operation is running.
    always @(negedge clk) begin
        exp_t e;
        if (rst8 === 1'b0) begin
            if (done8 === 1'b1) begin
                checkOutput("busy8_during_done", {31'd0, busy8}, 32'd0);
                if (q8.size() == 0) begin
                    checkOutput("unexpected_done8", {31'd0, done8}, 32'd0);
                end else begin
                    e = q8.pop_front();
                    checkOutput("s8",       {24'd0, s8},    {16'd0, e.s});
                    checkOutput("cout8",    {31'd0, cout8}, {31'd0, e.cout});
                    checkOutput("ovf8",     {31'd0, ovf8},  {31'd0, e.ovf});
                    checkOutput("latency8", cycle_cnt,      e.cyc);
                    last_s8 = e.s[7:0];
                end
            end else if (busy8 === 1'b1) begin
                checkOutput("hold_s8", {24'd0, s8}, {24'd0, last_s8});
            end
        end
        if (rst16 === 1'b0) begin
            if (done16 === 1'b1) begin
                checkOutput("busy16_during_done", {31'd0, busy16}, 32'd0);
                if (q16.size() == 0) begin
                    checkOutput("unexpected_done16", {31'd0, done16}, 32'd0);
                end else begin
                    e = q16.pop_front();
                    checkOutput("s16",       {16'd0, s16},    {16'd0, e.s});
                    checkOutput("cout16",    {31'd0, cout16}, {31'd0, e.cout});
                    checkOutput("ovf16",     {31'd0, ovf16},  {31'd0, e.ovf});
                    checkOutput("latency16", cycle_cnt,       e.cyc);
                    last_s16 = e.s;
                end
            end else if (busy16 === 1'b1) begin
                checkOutput("hold_s16", {16'd0, s16}, {16'd0, last_s16});
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        exp_t e;
        logic [15:0] ra, rb;
        logic        rs, rc;

        n_checks = 0; n_fail = 0;
        last_s8 = '0; last_s16 = '0;
        rst8 = 1'b1; rst16 = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_s8",     {24'd0, s8},     32'd0);
        checkOutput("rst_busy8",  {31'd0, busy8},  32'd0);
        checkOutput("rst_done8",  {31'd0, done8},  32'd0);
        checkOutput("rst_cout8",  {31'd0, cout8},  32'd0);
        checkOutput("rst_ovf8",   {31'd0, ovf8},   32'd0);
        checkOutput("rst_s16",    {16'd0, s16},    32'd0);
        checkOutput("rst_busy16", {31'd0, busy16}, 32'd0);
        rst8 = 1'b0; rst16 = 1'b0;
        @(negedge clk);

        $display("[TB] 8-bit directed cases");
        applyStimulus8(8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0); waitDone8();
        @(negedge clk);
        applyStimulus8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); waitDone8();
        applyStimulus8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1); waitDone8();
        applyStimulus8(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0); waitDone8();
        applyStimulus8(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1); waitDone8();

        $display("[TB] 8-bit start during RUN, then start on the done cycle");
        @(negedge clk);
        applyStimulus8(8'h3C, 8'h15, 1'b0, 1'b0, 8'h51, 1'b0, 1'b0);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waitDone8();
        applyStimulus8(8'h10, 8'h20, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b0); waitDone8();
        @(negedge clk);
        checkOutput("done8_one_cycle", {31'd0, done8}, 32'd0);

        $display("[TB] 8-bit random cases");
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            e = model(8, ra, rb, rs, rc);
            applyStimulus8(ra[7:0], rb[7:0], rs, rc, e.s[7:0], e.cout, e.ovf);
            waitDone8();
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("[TB] 16-bit directed and random cases");
        applyStimulus16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); waitDone16();
        applyStimulus16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); waitDone16();
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0); waitDone16();
        applyStimulus16(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0); waitDone16();
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            e = model(16, ra, rb, rs, rc);
            applyStimulus16(ra, rb, rs, rc, e.s, e.cout, e.ovf);
            waitDone16();
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("[TB] 16-bit reset in the middle of RUN");
        applyStimulus16(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0); waitDone16();
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst16 = 1'b1;
        last_s16 = '0;
        #1;
        checkOutput("abort_s16",    {16'd0, s16},    32'd0);
        checkOutput("abort_cout16", {31'd0, cout16}, 32'd0);
        checkOutput("abort_ovf16",  {31'd0, ovf16},  32'd0);
        checkOutput("abort_busy16", {31'd0, busy16}, 32'd0);
        checkOutput("abort_done16", {31'd0, done16}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst16 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("idle_s16_after_abort",    {16'd0, s16},    32'd0);
            checkOutput("idle_done16_after_abort", {31'd0, done16}, 32'd0);
        end

        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        applyStimulus16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0); waitDone16();
        @(negedge clk);
        @(negedge clk);

        checkOutput("q8_drained",  q8.size(),  32'd0);
        checkOutput("q16_drained", q16.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
